// File: rtl/wb_bridge_regslice_if.sv
// Wishbone B3 classic bus bundle used on both sides of wb_bridge_regslice.
// master drives the request and samples the termination; slave is the mirror.
interface wb_bridge_regslice_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [DATA_W-1:0] dat_r;
    logic [SEL_W-1:0]  sel;
    logic [2:0]        cti;
    logic [1:0]        bte;
    logic              ack;
    logic              err;
    logic              rty;

    modport master (
        output cyc, stb, we, adr, dat_w, sel, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_bridge_regslice.sv
// Registered Wishbone B3 bridge with automatic retry absorption; every output is a flop.
// Define WB_BRIDGE_TIMEOUT_EN to add an ISSUE watchdog that answers ERR after TIMEOUT_CYCLES.
module wb_bridge_regslice #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned RETRY_GAP      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_bridge_regslice_if.slave  s_bus,
    wb_bridge_regslice_if.master m_bus,
    output logic                 busy
);
    localparam int unsigned SEL_W = DATA_W / 8;

    if (MAX_RETRY > 15 || RETRY_GAP < 1 || RETRY_GAP > 255 || TIMEOUT_CYCLES < 1 ||
        DATA_W % 8 != 0) begin : g_param_check
        $error("wb_bridge_regslice: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StBackoff, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        retry_cnt_q, retry_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              cyc_q, cyc_d, stb_q, stb_d, busy_q, busy_d;
    logic              ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic              load_req, load_rdata;
    logic              timeout;

    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdat_q, rdat_q;
    logic [SEL_W-1:0]  sel_q;
    logic              we_q;
    logic [2:0]        cti_q;
    logic [1:0]        bte_q;

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    assign timeout  = (to_cnt_q == ToW'(TIMEOUT_CYCLES));
    // Restarts on every entry into ISSUE, so each re-issue gets a fresh budget.
    assign to_cnt_d = (state_q == StIssue && state_d == StIssue) ? to_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rty_d       = 1'b0;
        load_req    = 1'b0;
        load_rdata  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s_bus.cyc && s_bus.stb) begin
                    load_req    = 1'b1;
                    retry_cnt_d = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // Abort beats any termination arriving in the same cycle.
                if (!s_bus.cyc) begin
                    state_d = StIdle;
                end else if (m_bus.ack) begin
                    load_rdata = !we_q;
                    ack_d      = 1'b1;
                    state_d    = StResp;
                end else if (m_bus.err) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (m_bus.rty) begin
                    if (retry_cnt_q == 4'(MAX_RETRY)) begin
                        rty_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        gap_cnt_d   = '0;
                        state_d     = StBackoff;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StBackoff: begin
                if (!s_bus.cyc) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == 8'(RETRY_GAP - 1)) begin
                    state_d = StIssue;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cyc_d  = (state_d == StIssue) || (state_d == StBackoff);
        stb_d  = (state_d == StIssue);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            retry_cnt_q <= '0;
            gap_cnt_q   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rty_q       <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cti_q       <= '0;
            bte_q       <= '0;
            rdat_q      <= '0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rty_q       <= rty_d;
            if (load_req) begin
                adr_q  <= s_bus.adr;
                wdat_q <= s_bus.dat_w;
                sel_q  <= s_bus.sel;
                we_q   <= s_bus.we;
                cti_q  <= s_bus.cti;
                bte_q  <= s_bus.bte;
            end
            if (load_rdata) begin
                rdat_q <= m_bus.dat_r;
            end
        end
    end

    assign m_bus.cyc   = cyc_q;
    assign m_bus.stb   = stb_q;
    assign m_bus.we    = we_q;
    assign m_bus.adr   = adr_q;
    assign m_bus.dat_w = wdat_q;
    assign m_bus.sel   = sel_q;
    assign m_bus.cti   = cti_q;
    assign m_bus.bte   = bte_q;

    assign s_bus.dat_r = rdat_q;
    assign s_bus.ack   = ack_q;
    assign s_bus.err   = err_q;
    assign s_bus.rty   = rty_q;

    assign busy = busy_q;
endmodule
